// File: rtl/image_blitter.sv
// image_blitter: streams one of N_IMG background ROMs into the vga_adapter plot interface
//
// Ports:
//   clk, resetn        system clock, asynchronous active-low reset
//   start, img_sel     request to copy image img_sel (accepted from IDLE, or as preemption while busy)
//   rom_img, rom_addr  image being copied and ROM read address
//   rom_q              ROM data, valid ROM_LAT cycles after rom_addr
//   x, y, colour, plot plot interface; x/y/colour hold their last value while plot=0
//   busy, done         busy in RUN/DRAIN; one-cycle done pulse on frame completion
//
// Build option: define BLIT_TRANSPARENT_EN to suppress plotting of pixels equal to KEY_COLOUR.
module image_blitter #(
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 120,
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int ADDR_BITS   = 15,
    parameter int N_IMG       = 2,
    parameter int SEL_BITS    = 1,
    parameter int COLOUR_BITS = 3,
`ifdef BLIT_TRANSPARENT_EN
    parameter logic [COLOUR_BITS-1:0] KEY_COLOUR = '0,
`endif
    parameter int ROM_LAT     = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [SEL_BITS-1:0]    img_sel,
    output logic [SEL_BITS-1:0]    rom_img,
    output logic [ADDR_BITS-1:0]   rom_addr,
    input  logic [COLOUR_BITS-1:0] rom_q,
    output logic [X_BITS-1:0]      x,
    output logic [Y_BITS-1:0]      y,
    output logic [COLOUR_BITS-1:0] colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                 r_state, w_next;
    logic [X_BITS-1:0]      r_x, r_hx;
    logic [Y_BITS-1:0]      r_y, r_hy;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [SEL_BITS-1:0]    r_img;
    logic [COLOUR_BITS-1:0] r_hc;
    logic [ROM_LAT-1:0]     r_vld, w_vsh;
    logic [X_BITS-1:0]      r_dx [ROM_LAT];
    logic [Y_BITS-1:0]      r_dy [ROM_LAT];
    logic                   w_run, w_last, w_xwrap, w_go, w_plot;

    assign w_run   = r_state == S_RUN;
    assign w_last  = r_addr == ADDR_BITS'(WIDTH*HEIGHT-1);
    assign w_xwrap = r_x == X_BITS'(WIDTH-1);
    assign busy    = w_run || r_state == S_DRAIN;
    assign done    = r_state == S_DONE;
    // accepted from IDLE, or while busy only when it names a different image (preemption)
    assign w_go    = start && 32'(img_sel) < N_IMG && (r_state == S_IDLE || (busy && img_sel != r_img));
    // valid bits behind the output stage; all clear means the last pixel is emerging now
    assign w_vsh   = r_vld << 1;
`ifdef BLIT_TRANSPARENT_EN
    assign w_plot  = r_vld[ROM_LAT-1] && rom_q != KEY_COLOUR;
`else
    assign w_plot  = r_vld[ROM_LAT-1];
`endif
    assign plot     = w_plot;
    assign x        = w_plot ? r_dx[ROM_LAT-1] : r_hx;
    assign y        = w_plot ? r_dy[ROM_LAT-1] : r_hy;
    assign colour   = w_plot ? rom_q : r_hc;
    assign rom_img  = r_img;
    assign rom_addr = r_addr;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;

    always_comb begin
        w_next = r_state;
        w_next = w_go                                 ? S_RUN   :
                 (w_run && w_last)                    ? S_DRAIN :
                 (r_state == S_DRAIN && w_vsh == '0)  ? S_DONE  :
                 (r_state == S_DONE)                  ? S_IDLE  : r_state;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_img  <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
            r_vld  <= '0;
            r_hx   <= '0;
            r_hy   <= '0;
            r_hc   <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                r_dx[i] <= '0;
                r_dy[i] <= '0;
            end
        end else begin
            if (w_go) begin
                r_img  <= img_sel;
                r_x    <= '0;
                r_y    <= '0;
                r_addr <= '0;
            end else if (w_run && !w_last) begin
                r_x    <= w_xwrap ? '0 : r_x + 1'b1;
                r_y    <= w_xwrap ? r_y + 1'b1 : r_y;
                r_addr <= r_addr + 1'b1;
            end
            // a preempting request flushes everything in flight, including this cycle's issue
            r_vld    <= w_go ? '0 : w_vsh | ROM_LAT'(w_run);
            r_dx[0]  <= r_x;
            r_dy[0]  <= r_y;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_dx[i] <= r_dx[i-1];
                r_dy[i] <= r_dy[i-1];
            end
            if (w_plot) begin
                r_hx <= r_dx[ROM_LAT-1];
                r_hy <= r_dy[ROM_LAT-1];
                r_hc <= rom_q;
            end
        end
    end
endmodule

// File: tb/tb_image_blitter.sv
// tb_image_blitter: checks image_blitter (ROM_LAT=1 and ROM_LAT=3 instances) against a pixel-sequence model
module tb_image_blitter;
    localparam int W = 160, H = 120, NPIX = W*H;
`ifdef BLIT_TRANSPARENT_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic       clk = 1'b0, resetn = 1'b0, start = 1'b0;
    logic [0:0] img_sel = 1'b0;
    logic       img_w [2], plot_w [2], busy_w [2], done_w [2];
    logic [14:0] addr_w [2];
    logic [7:0] x_w [2];
    logic [6:0] y_w [2];
    logic [2:0] col_w [2], q_w [2];
    logic [2:0] rp1;
    logic [2:0] rp3 [3];

    always #5 clk = ~clk;

    image_blitter #(.ROM_LAT(1)) u1 (
        .clk(clk), .resetn(resetn), .start(start), .img_sel(img_sel),
        .rom_img(img_w[0]), .rom_addr(addr_w[0]), .rom_q(q_w[0]),
        .x(x_w[0]), .y(y_w[0]), .colour(col_w[0]),
        .plot(plot_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    image_blitter #(.ROM_LAT(3)) u3 (
        .clk(clk), .resetn(resetn), .start(start), .img_sel(img_sel),
        .rom_img(img_w[1]), .rom_addr(addr_w[1]), .rom_q(q_w[1]),
        .x(x_w[1]), .y(y_w[1]), .colour(col_w[1]),
        .plot(plot_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    function automatic logic [2:0] rom(input int img, input int a);
        return 3'(a) ^ (img == 1 ? 3'd5 : 3'd2);
    endfunction

    function automatic bit vis(input int img, input int a);
        return !(TRANSP && rom(img, a) == 3'd0);
    endfunction

    always @(posedge clk) begin
        rp1    <= rom(int'(img_w[0]), int'(addr_w[0]));
        rp3[0] <= rom(int'(img_w[1]), int'(addr_w[1]));
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign q_w[0] = rp1;
    assign q_w[1] = rp3[2];

    int cyc = 0, checks = 0, errors = 0;
    int k [2], nstr [2], bad [2], badimg [2], first [2], last [2], ndone [2], donec [2], imgm [2];
    int bk [2], bx [2], by [2], bc [2];

    typedef struct {
        bit st; bit sel; bit busy; bit plot; int addr; bit img; int x; int y; int c;
    } vec_t;
    vec_t tv [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic observe();
        for (int d = 0; d < 2; d++) begin
            if (plot_w[d]) begin
                while (k[d] < NPIX && !vis(imgm[d], k[d])) k[d]++;
                if (nstr[d] == 0) first[d] = cyc;
                last[d] = cyc;
                nstr[d]++;
                if (k[d] >= NPIX || int'(x_w[d]) != k[d] % W || int'(y_w[d]) != k[d] / W ||
                    col_w[d] != rom(imgm[d], k[d])) begin
                    if (bad[d] == 0) begin
                        bk[d] = k[d]; bx[d] = int'(x_w[d]); by[d] = int'(y_w[d]); bc[d] = int'(col_w[d]);
                    end
                    bad[d]++;
                end
                k[d]++;
            end
            if (done_w[d]) begin
                ndone[d]++;
                donec[d] = cyc;
            end
            if (busy_w[d] && int'(img_w[d]) != imgm[d]) badimg[d]++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        observe();
    endtask

    task automatic arm(input int s);
        for (int d = 0; d < 2; d++) begin
            k[d] = 0; nstr[d] = 0; bad[d] = 0; badimg[d] = 0;
            first[d] = -1; last[d] = -1; ndone[d] = 0; donec[d] = -1; imgm[d] = s;
        end
    endtask

    task automatic begin_frame(input int s, output int t0);
        arm(s);
        img_sel = 1'(s);
        start = 1'b1;
        tick();
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < NPIX + 20 && !(ndone[0] > 0 && ndone[1] > 0); i++) tick();
    endtask

    task automatic check_frame(input string tag, input int t0);
        for (int d = 0; d < 2; d++) begin
            int cnt = 0, kf = -1, kl = -1, lat = d ? 3 : 1;
            for (int a = 0; a < NPIX; a++)
                if (vis(imgm[d], a)) begin
                    if (kf < 0) kf = a;
                    kl = a;
                    cnt++;
                end
            chk($sformatf("%s/lat%0d strobes", tag, lat), nstr[d], cnt);
            chk($sformatf("%s/lat%0d first strobe offset", tag, lat), first[d] - t0, lat + kf);
            chk($sformatf("%s/lat%0d last strobe offset", tag, lat), last[d] - t0, lat + kl);
            chk($sformatf("%s/lat%0d done offset", tag, lat), donec[d] - t0, NPIX + lat);
            chk($sformatf("%s/lat%0d done pulses", tag, lat), ndone[d], 1);
            chk($sformatf("%s/lat%0d bad pixels", tag, lat), bad[d], 0);
            if (bad[d] > 0)
                $display("  first bad pixel index %0d: x=%0d y=%0d colour=%0d", bk[d], bx[d], by[d], bc[d]);
            chk($sformatf("%s/lat%0d rom_img while busy", tag, lat), badimg[d], 0);
        end
    endtask

    initial begin
        int t0, s, n, act;
        tv[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1, 0, 0, 0};
        tv[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b1, 0, 0, 5};
        tv[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1, 0, 4};
        tv[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1, 0, 4};
        tv[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 0, 0, 2};
        tv[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1, 0, 3};
        arm(0);

        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset plot %0d", d), int'(plot_w[d]), 0);
            chk($sformatf("reset busy %0d", d), int'(busy_w[d]), 0);
            chk($sformatf("reset done %0d", d), int'(done_w[d]), 0);
            chk($sformatf("reset addr %0d", d), int'(addr_w[d]), 0);
            chk($sformatf("reset xyc %0d", d), int'({x_w[d], y_w[d], col_w[d]}), 0);
            chk($sformatf("reset rom_img %0d", d), int'(img_w[d]), 0);
        end
        #1 resetn = 1'b1;
        tick();
        tick();
        chk("idle without start", int'(busy_w[0]) + int'(busy_w[1]), 0);

        for (int i = 0; i < 6; i++) begin
            start = tv[i].st;
            img_sel = tv[i].sel;
            tick();
            chk($sformatf("vec%0d busy", i), int'(busy_w[0]), int'(tv[i].busy));
            chk($sformatf("vec%0d plot", i), int'(plot_w[0]), int'(tv[i].plot));
            chk($sformatf("vec%0d addr", i), int'(addr_w[0]), tv[i].addr);
            chk($sformatf("vec%0d rom_img", i), int'(img_w[0]), int'(tv[i].img));
            chk($sformatf("vec%0d x", i), int'(x_w[0]), tv[i].x);
            chk($sformatf("vec%0d y", i), int'(y_w[0]), tv[i].y);
            chk($sformatf("vec%0d colour", i), int'(col_w[0]), tv[i].c);
        end
        start = 1'b0;
        resetn = 1'b0;
        tick();
        #1 resetn = 1'b1;

        begin_frame(1, t0);
        for (int i = 0; i < NPIX + 20 && !(ndone[0] > 0 && ndone[1] > 0); i++) begin
            start = done_w[0] ? 1'b1 : (ndone[0] == 0 ? ($urandom_range(0, 1999) == 0) : 1'b0);
            tick();
        end
        start = 1'b0;
        act = 0;
        repeat (10) begin
            tick();
            act += int'(busy_w[0]) + int'(plot_w[0]) + int'(done_w[0]);
        end
        chk("A start in DONE ignored", act, 0);
        check_frame("A", t0);

        begin_frame(0, t0);
        for (int i = 0; i < 6000 && nstr[0] < 5000; i++) tick();
        chk("B strobes before preempt", nstr[0], 5000);
        begin_frame(1, t0);
        wait_done();
        repeat (3) tick();
        check_frame("B", t0);

        s = int'($urandom_range(0, 1));
        begin_frame(s, t0);
        n = int'($urandom_range(1000, 15000));
        repeat (n) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        repeat (3) tick();
        check_frame("C", t0);

        begin_frame(int'($urandom_range(0, 1)), t0);
        for (int i = 0; i < 200 && nstr[0] < 100; i++) tick();
        chk("D strobes before reset", nstr[0], 100);
        #2 resetn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("D async plot %0d", d), int'(plot_w[d]), 0);
            chk($sformatf("D async busy %0d", d), int'(busy_w[d]), 0);
            chk($sformatf("D async done %0d", d), int'(done_w[d]), 0);
            chk($sformatf("D async addr %0d", d), int'(addr_w[d]), 0);
        end
        tick();
        tick();
        #1 resetn = 1'b1;
        act = 0;
        repeat (30) begin
            tick();
            for (int d = 0; d < 2; d++) act += int'(busy_w[d]) + int'(plot_w[d]) + int'(done_w[d]);
        end
        chk("D quiet after reset release", act, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
